// File: rtl/reg_bank8_sweep.sv
// reg_bank8_sweep: upstream feeder for a Mux8Way16 stage.
// Eight WIDTH-bit registers drive the mux data inputs a..h through a single
// addressed write port. A sweep sequencer drives sel through 0..7, holding
// each value for DWELL clocks. It runs one pass per start pulse, or runs
// back-to-back passes while cont is high.
//
// Optional build macro REG_BANK8_CLEAR_EN adds a 'clear' input. Clear zeroes
// all eight registers and does not touch the sequencer.
//
// Handshake semantics: load is a fire-and-forget write strobe with an
// implicit ready of 1. Every edge with load=1 is a completed write, in any
// state. start is a request that is only consumed in IDLE and is otherwise
// dropped. done is a single-cycle valid pulse with no back-pressure.
//
// Debug: state_dbg exposes the sequencer state (0 = IDLE, 1 = RUN).

module reg_bank8_sweep #(
    parameter int WIDTH = 16,
    parameter int DWELL = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    input  logic             start,
    input  logic             cont,
`ifdef REG_BANK8_CLEAR_EN
    input  logic             clear,
`endif
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [2:0]       sel,
    output logic             busy,
    output logic             done,
    output logic             state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Last dwell count before sel advances; the dwell counter is 8 bits wide.
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    logic [7:0][WIDTH-1:0] regs_q, regs_d;

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] dwell_q, dwell_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Register write path: clear (when built in) beats load; writes never stall the sweep.
    always_comb begin
        regs_d = regs_q;
`ifdef REG_BANK8_CLEAR_EN
        if (clear) begin
            regs_d = '0;
        end else if (load) begin
            regs_d[address] = in;
        end
`else
        if (load) begin
            regs_d[address] = in;
        end
`endif
    end

    // Register bank storage with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Sweep sequencer next-state: dwell counting, sel stepping, wrap/done, cont handling.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dwell_d = dwell_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    sel_d   = 3'd0;
                    dwell_d = 8'd0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = 8'd0;
                    if (sel_q != 3'd7) begin
                        sel_d = sel_q + 3'd1;
                    end else begin
                        // End of pass: pulse done and wrap; cont decides whether to keep going.
                        done_d = 1'b1;
                        sel_d  = 3'd0;
                        if (!cont) begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state register; reset aborts any sweep without a done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            dwell_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a = regs_q[0];
    assign b = regs_q[1];
    assign c = regs_q[2];
    assign d = regs_q[3];
    assign e = regs_q[4];
    assign f = regs_q[5];
    assign g = regs_q[6];
    assign h = regs_q[7];

    assign sel       = sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_reg_bank8_sweep.sv
// Testbench for reg_bank8_sweep. A driver issues one cycle of stimulus and
// pushes the expected post-edge outputs into exp_q. A negedge monitor pops
// each entry and compares it against the DUT outputs.

module tb_reg_bank8_sweep;

  localparam int W     = 16;
  localparam int DWELL = 4;
`ifdef REG_BANK8_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  typedef struct packed {
    int               id;
    logic [2:0]       sel;
    logic             busy;
    logic             done;
    logic [7:0][W-1:0] regs;
  } exp_t;

  exp_t exp_q[$];

  logic         clock;
  logic         reset;
  logic [W-1:0] in;
  logic         load;
  logic [2:0]   address;
  logic         start;
  logic         cont;
`ifdef REG_BANK8_CLEAR_EN
  logic         clear;
`endif
  logic [W-1:0] a, b, c, d, e, f, g, h;
  logic [2:0]   sel;
  logic         busy;
  logic         done;
  logic         state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_id   = 0;
  logic [7:0][W-1:0] mdl_regs = '0;
  logic [W-1:0] vals [8] = '{16'h1234, 16'h2345, 16'h3456, 16'h4567,
                             16'h5678, 16'h6789, 16'h789A, 16'h89AB};

  reg_bank8_sweep #(.WIDTH(W), .DWELL(DWELL)) dut (
    .clock(clock), .reset(reset), .in(in), .load(load), .address(address),
    .start(start), .cont(cont),
`ifdef REG_BANK8_CLEAR_EN
    .clear(clear),
`endif
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .sel(sel), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, id, got, exp);
    end
  endtask

  // Scoreboard monitor: compare each expected entry one half-cycle after its edge
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t ex;
      logic [7:0][W-1:0] got_regs;
      ex = exp_q.pop_front();
      got_regs = {h, g, f, e, d, c, b, a};
      chk("sel",  ex.id, 32'(sel),  32'(ex.sel));
      chk("busy", ex.id, 32'(busy), 32'(ex.busy));
      chk("done", ex.id, 32'(done), 32'(ex.done));
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("reg%0d", i), ex.id, 32'(got_regs[i]), 32'(ex.regs[i]));
      end
    end
  end

  // Driver: apply inputs for one edge, then queue the expected post-edge outputs
  task automatic cyc(input logic ld, input logic [2:0] ad, input logic [W-1:0] din,
                     input logic st, input logic ct, input logic rs, input logic clr,
                     input logic [2:0] e_sel, input logic e_busy, input logic e_done);
    exp_t ex;
    @(negedge clock);
    load = ld; address = ad; in = din; start = st; cont = ct; reset = rs;
`ifdef REG_BANK8_CLEAR_EN
    clear = clr;
`endif
    @(posedge clock);
    if (rs) mdl_regs = '0;
    else if (CLR_EN && clr) mdl_regs = '0;
    else if (ld) mdl_regs[ad] = din;
    ex.id = cyc_id; ex.sel = e_sel; ex.busy = e_busy; ex.done = e_done; ex.regs = mdl_regs;
    exp_q.push_back(ex);
    cyc_id++;
  endtask

  initial begin
    load = 0; address = 0; in = 0; start = 0; cont = 0; reset = 1;
`ifdef REG_BANK8_CLEAR_EN
    clear = 0;
`endif
    // Reset state
    cyc(0, 0, 0, 0, 0, 1, 0, 3'd0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 3'd0, 0, 0);

    // Test 1: load registers 0..7, one per cycle
    for (int i = 0; i < 8; i++) cyc(1, 3'(i), vals[i], 0, 0, 0, 0, 3'd0, 0, 0);

    // Test 2: single pass, cont=0; sel holds k/DWELL, done as sel wraps at 32
    for (int k = 0; k < 34; k++)
      cyc(0, 0, 0, k == 0, 0, 0, 0, (k >= 32) ? 3'd0 : 3'(k / DWELL), k < 32, k == 32);

    // Test 3: continuous for 70 clocks (done at 32, 64), then cont dropped: pass ends at 96
    for (int k = 0; k < 98; k++)
      cyc(0, 0, 0, k == 0, k < 70, 0, 0,
          (k >= 96) ? 3'd0 : 3'((k / DWELL) % 8), k < 96, (k == 32) || (k == 64) || (k == 96));

    // Test 4: write register[3] while sel=3; start pulses during RUN are ignored
    for (int k = 0; k < 34; k++)
      cyc(k == 13, 3'd3, 16'hBEEF, (k == 0) || (k == 14) || (k == 20), 0, 0, 0,
          (k >= 32) ? 3'd0 : 3'(k / DWELL), k < 32, k == 32);

    // Test 5: reset at sel=5 aborts the sweep with no done pulse
    for (int k = 0; k < 21; k++)
      cyc(0, 0, 0, k == 0, 0, 0, 0, 3'(k / DWELL), 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 3'd0, 0, 0);
    for (int k = 22; k < 40; k++) cyc(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0);

    // Test 6: reload, then start+load on the same edge; clear+load mid-sweep
    for (int i = 0; i < 8; i++) cyc(1, 3'(i), vals[i], 0, 0, 0, 0, 3'd0, 0, 0);
    for (int k = 0; k < 34; k++)
      cyc((k == 0) || (k == 10), (k == 0) ? 3'd0 : 3'd2, (k == 0) ? 16'hCAFE : 16'hFFFF,
          k == 0, 0, 0, k == 10, (k >= 32) ? 3'd0 : 3'(k / DWELL), k < 32, k == 32);

    // Drain scoreboard with a bounded wait
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clock);
    @(posedge clock);
    chk("drain", cyc_id, 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank8_sweep.md
Name: reg_bank8_sweep

Overview:
- Upstream feeder for the Mux8Way16 stage.
- Holds eight WIDTH-bit registers whose outputs drive the mux data inputs a..h, and generates the 3-bit sel sequence that sweeps 0..7.
- Registers are written through a single addressed write port.
- The sweep sequencer steps sel every DWELL clocks, running either one pass per start pulse or continuously.

Parameters:
- WIDTH, 16, data width of each register and of in/a..h.
- DWELL, 4, clocks each sel value is held (legal 1..255).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  write data.
- load  input  1  write enable; writes in to register[address].
- address  input  3  write index.
- start  input  1  begin a sweep; sampled only in IDLE.
- cont  input  1  when 1 at pass end, the next pass starts without a new start.
- a,b,c,d,e,f,g,h  output  WIDTH each  register[0]..register[7], direct register outputs.
- sel  output  3  current sweep index.
- busy  output  1  high while a sweep is RUN.
- done  output  1  one-cycle pulse after the last dwell of a pass.

Behaviour:
- Reset values (applied on a clock edge with reset=1): a..h=0, sel=0, busy=0, done=0, dwell counter=0, state=IDLE.
- Reset mid-sweep aborts the sweep on that edge; no done pulse is issued.
- Write path:
  - On an edge with load=1, register[address] <= in.
  - The matching output a..h shows the new value the cycle after the edge (one-cycle latency).
  - Writes are accepted in any state and never stall the sweep.
- States:
  - IDLE: busy=0, sel holds its last value. If start=1: sel<=0, dwell<=0, busy<=1, go to RUN.
  - RUN: dwell increments each clock. When dwell==DWELL-1: dwell<=0 and
    - if sel!=7: sel<=sel+1;
    - if sel==7: done<=1 for one cycle, sel<=0 (wrap). If cont=1 stay in RUN; otherwise busy<=0 and go to IDLE.
- Timing: each sel value is held exactly DWELL clocks. With cont=0, a pass lasts 8*DWELL clocks from the first RUN cycle.
- done:
  - Asserts on the same edge that sel wraps 7->0.
  - In continuous mode it pulses once per pass.
- start:
  - Ignored while in RUN; it does not restart the pass.
  - start and load on the same edge are both honoured.
- Boundary cases:
  - DWELL=1: sel changes every clock.
  - Writing register[sel] while sel points at it: the new value appears on that output next cycle, with no glitch on other outputs.
  - cont dropped mid-pass: the pass completes, then the block goes to IDLE.
- Arithmetic: the dwell counter is 8 bits. sel is 3 bits and wraps naturally; no other modular arithmetic is used.

Optional Feature:
- Macro: REG_BANK8_CLEAR_EN.
- Defined:
  - Adds input port clear (1 bit).
  - On an edge with clear=1 and reset=0, all eight registers go to 0; sel, the state machine and the dwell counter are unaffected.
  - Priority: reset > clear > load. A load on the same edge as clear is dropped.
- Not defined:
  - No clear port.
  - Registers change only via reset or load.

Test Plan:
1. Reset, then load registers 0..7 with 16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6789, 16'h789A, 16'h89AB -> each of a..h equals its value one cycle after its write; all others stay 0 until written.
2. DWELL=4, cont=0, pulse start -> busy rises next cycle; sel follows 0,0,0,0,1,...,7,7,7,7 (32 clocks); done pulses once as sel wraps to 0; busy=0 after.
3. cont=1, start once, run 70 clocks with DWELL=4 -> sel wraps twice; done pulses at clocks 32 and 64 after start; busy stays 1.
4. Mid-sweep at sel=3, write register[3]=16'hBEEF -> d=16'hBEEF next cycle; sel timing unchanged; start pulsed during RUN has no effect.
5. Assert reset at sel=5 in RUN -> next edge: sel=0, busy=0, a..h=0, no done pulse.
6. With REG_BANK8_CLEAR_EN: registers loaded, clear=1 with load=1, address=2, in=16'hFFFF on the same edge -> all a..h=0 next cycle; the sweep keeps running.
